// File: rtl/multicycle_ctrl_if.sv
// multicycle_ctrl_if: sequencer-to-datapath bundle of status inputs, strobes and selects
interface multicycle_ctrl_if #(
    parameter int CNT_W = 32
);
    logic [6:0]       opcode;
    logic             alu_zero;
    logic             imem_ready;
    logic             dmem_ready;
    logic             halt_req;
    logic             ir_wr_en;
    logic             pc_wr_en;
    logic             pc_select;
    logic             alu_src2_sel;
    logic [1:0]       alu_op;
    logic             mem_read;
    logic             mem_write;
    logic             mem_to_reg;
    logic             rf_wr_en;
    logic             illegal;
    logic             bus_err;
    logic             halted;
    logic [CNT_W-1:0] retired_cnt;
    modport master (
        input  opcode, alu_zero, imem_ready, dmem_ready, halt_req,
        output ir_wr_en, pc_wr_en, pc_select, alu_src2_sel, alu_op,
        output mem_read, mem_write, mem_to_reg, rf_wr_en,
        output illegal, bus_err, halted, retired_cnt
    );
    modport slave (
        output opcode, alu_zero, imem_ready, dmem_ready, halt_req,
        input  ir_wr_en, pc_wr_en, pc_select, alu_src2_sel, alu_op,
        input  mem_read, mem_write, mem_to_reg, rf_wr_en,
        input  illegal, bus_err, halted, retired_cnt
    );
endinterface

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: FETCH/DECODE/EXEC/MEM/WB sequencer with halt, illegal-opcode and bus-timeout handling
module multicycle_ctrl #(
    parameter int CNT_W   = 32,
    parameter int TIMEOUT = 255
) (
    input logic               clk,
    input logic               reset,
    multicycle_ctrl_if.master bus
);
    localparam int WW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [WW-1:0] WLAST = WW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    typedef enum logic [2:0] {FETCH, DECODE, EXEC, MEM, WB, HALT, ERROR} state_e;
    typedef enum logic [2:0] {C_R, C_I, C_LD, C_ST, C_BR, C_ILL} cls_e;

    state_e           state_q, state_d;
    cls_e             cls_q, cls_d, op_cls;
    logic [WW-1:0]    wait_q, wait_d;
    logic             illegal_q, illegal_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             retire;
    logic             timed_out;

    // classify the opcode; only meaningful while the IR is stable from DECODE on
    always_comb begin
        op_cls = (bus.opcode == 7'b0110011) ? C_R  :
                 (bus.opcode == 7'b0010011) ? C_I  :
                 (bus.opcode == 7'b0000011) ? C_LD :
                 (bus.opcode == 7'b0100011) ? C_ST :
                 (bus.opcode == 7'b1100011) ? C_BR : C_ILL;
    end

    // state register plus class, wait counter, sticky illegal flag and retire counter
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= FETCH;
            cls_q     <= C_R;
            wait_q    <= '0;
            illegal_q <= 1'b0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            cls_q     <= cls_d;
            wait_q    <= wait_d;
            illegal_q <= illegal_d;
            cnt_q     <= cnt_d;
        end
    end

    // next state; a ready seen in the last allowed wait cycle beats the timeout
    always_comb begin
        timed_out = (TIMEOUT != 0) && (wait_q == WLAST);
        state_d   = state_q;
        case (state_q)
            FETCH:   state_d = bus.halt_req ? HALT : bus.imem_ready ? DECODE : timed_out ? ERROR : FETCH;
            DECODE:  state_d = (op_cls == C_ILL) ? FETCH : EXEC;
            EXEC:    state_d = (cls_q == C_BR) ? FETCH : (cls_q inside {C_LD, C_ST}) ? MEM : WB;
            MEM:     state_d = bus.dmem_ready ? ((cls_q == C_ST) ? FETCH : WB) : timed_out ? ERROR : MEM;
            WB:      state_d = FETCH;
            HALT:    state_d = bus.halt_req ? HALT : FETCH;
            default: state_d = ERROR;
        endcase
        cls_d     = (state_q == DECODE) ? op_cls : cls_q;
        illegal_d = illegal_q | (state_q == DECODE && op_cls == C_ILL);
        wait_d    = (state_d == state_q && (state_q == FETCH || state_q == MEM)) ? wait_q + WW'(1) : '0;
        cnt_d     = cnt_q + CNT_W'(retire);
    end

    // strobes and selects; everything is forced low while reset is held
    always_comb begin
        bus.ir_wr_en     = 1'b0;
        bus.pc_wr_en     = 1'b0;
        bus.pc_select    = 1'b0;
        bus.alu_src2_sel = 1'b0;
        bus.alu_op       = 2'b00;
        bus.mem_read     = 1'b0;
        bus.mem_write    = 1'b0;
        bus.mem_to_reg   = 1'b0;
        bus.rf_wr_en     = 1'b0;
        bus.halted       = 1'b0;
        bus.illegal      = !reset && illegal_q;
        bus.bus_err      = !reset && state_q == ERROR;
        bus.retired_cnt  = reset ? '0 : cnt_q;
        retire           = 1'b0;
        if (!reset) begin
            case (state_q)
                FETCH:  bus.ir_wr_en = !bus.halt_req && bus.imem_ready;
                DECODE: bus.pc_wr_en = op_cls == C_ILL;
                EXEC: begin
                    bus.alu_src2_sel = cls_q inside {C_I, C_LD, C_ST};
                    bus.alu_op       = (cls_q == C_R) ? 2'b10 : (cls_q == C_I) ? 2'b11 : (cls_q == C_BR) ? 2'b01 : 2'b00;
                    bus.pc_wr_en     = cls_q == C_BR;
                    bus.pc_select    = cls_q == C_BR && bus.alu_zero;
                    retire           = cls_q == C_BR;
                end
                MEM: begin
                    bus.alu_src2_sel = 1'b1;
                    bus.mem_read     = cls_q == C_LD;
                    bus.mem_write    = cls_q == C_ST;
                    bus.pc_wr_en     = bus.dmem_ready && cls_q == C_ST;
                    retire           = bus.dmem_ready && cls_q == C_ST;
                end
                WB: begin
                    bus.rf_wr_en   = 1'b1;
                    bus.mem_to_reg = cls_q == C_LD;
                    bus.pc_wr_en   = 1'b1;
                    retire         = 1'b1;
                end
                HALT:    bus.halted = 1'b1;
                default: ;
            endcase
        end
    end
endmodule
